array_stats_ctrl: RTL and testbench

Sequenced statistics engine for the 15-entry, 8-bit sample array used by the array statistics blocks. It buffers samples through a valid/ready input stream. On a `start` command it computes one statistic over the held array, serially, on shared compare/accumulate hardware: average, median or mode. It returns the result through a valid/ready output handshake. The buffer is kept after each result, so several statistics can run on the same data without reloading it.

---
 rtl/array_stats_pkg.sv | 26 ++
 rtl/array_stats_if.sv | 29 ++
 rtl/array_stats_div.sv | 57 +++++
 rtl/array_stats_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_array_stats_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/array_stats_pkg.sv
// Shared constants and types for the array statistics engine.
// Contents: array geometry (N, DATA_W), datapath widths (SUM_W, CNT_W),
// op encodings and the controller state enum.
package array_stats_pkg;

  localparam int unsigned N       = 15;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned SUM_W   = 12;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MED_IDX = (N - 1) / 2;

  localparam logic [1:0] OP_AVG  = 2'd0;
  localparam logic [1:0] OP_MED  = 2'd1;
  localparam logic [1:0] OP_MODE = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FULL,
    ST_ACC,
    ST_DIV,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/array_stats_if.sv
// Sample stream, command and result handshake bundle of array_stats_ctrl.
// master: the client (drives samples, commands, res_ready).
// slave : the engine (drives in_ready, busy and the result).
interface array_stats_if;
  import array_stats_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              clear;
  logic              start;
  logic [1:0]        op;
  logic              busy;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_err;
  logic              res_ready;

  modport master (
    output in_valid, in_data, clear, start, op, res_ready,
    input  in_ready, busy, res_valid, res_data, res_err
  );

  modport slave (
    input  in_valid, in_data, clear, start, op, res_ready,
    output in_ready, busy, res_valid, res_data, res_err
  );

endinterface

// File: rtl/array_stats_div.sv
// Restoring divider: SUM_W-bit dividend by the constant N, one quotient bit
// per cycle, MSB first; SUM_W cycles after i_start.
// Ports: clk, rst_n (sync, active-low), i_clear (abort), i_start (load
// i_dividend), o_done_c (high in the last iteration cycle), o_quot_c (the
// quotient as it will be after that cycle's edge, low DATA_W bits).
module array_stats_div
  import array_stats_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic [SUM_W-1:0]  i_dividend,
  output logic              o_done_c,
  output logic [DATA_W-1:0] o_quot_c
);

  localparam int unsigned      TRIAL_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SUM_W - 1);

  logic               r_run;
  logic [CNT_W-1:0]   r_step;
  logic [CNT_W-1:0]   r_rem;
  logic [SUM_W-1:0]   r_quo;   // dividend bits shift out as quotient bits shift in
  logic [TRIAL_W-1:0] w_trial;
  logic               w_ge;
  logic [CNT_W-1:0]   w_rem_nx;
  logic [SUM_W-1:0]   w_quo_nx;

  // Remainder stays below N, so the trial value fits in CNT_W+1 bits.
  assign w_trial  = {r_rem, r_quo[SUM_W-1]};
  assign w_ge     = (w_trial >= TRIAL_W'(N));
  assign w_rem_nx = w_ge ? CNT_W'(w_trial - TRIAL_W'(N)) : CNT_W'(w_trial);
  assign w_quo_nx = {r_quo[SUM_W-2:0], w_ge};
  assign o_done_c = r_run && (r_step == LAST_STEP);
  assign o_quot_c = w_quo_nx[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_run  <= 1'b0;
      r_step <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
    end else if (i_start) begin
      r_run  <= 1'b1;
      r_step <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
    end else if (r_run) begin
      r_rem  <= w_rem_nx;
      r_quo  <= w_quo_nx;
      r_step <= r_step + CNT_W'(1);
      if (o_done_c) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/array_stats_ctrl.sv
// Sequenced statistics engine over a 15-entry, 8-bit sample buffer:
// average (accumulate + divide), median and mode (N*N compare scan).
// Ports: clk, rst_n (sync, active-low), bus (array_stats_if.slave: sample
// stream in, clear/start/op command, busy, result valid/ready handshake).
// Build option: ARRAY_STATS_MODE_EN enables op 2 (mode); without it op 2
// returns an error result like op 3.
module array_stats_ctrl
  import array_stats_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  array_stats_if.slave bus
);

  localparam int unsigned      TOT_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  state_e r_state, w_state_nx;

  logic              r_in_ready, r_busy, r_res_valid, r_res_err;
  logic [DATA_W-1:0] r_res_data;
  logic              w_in_ready_nx, w_busy_nx, w_res_valid_nx;

  logic [DATA_W-1:0] r_buf [N];
  logic [CNT_W-1:0]  r_count, r_idx, r_i, r_j, r_lt, r_eq;
  logic [SUM_W-1:0]  r_sum;
  logic              r_med_found;
  logic [DATA_W-1:0] r_med_val;

  logic              w_wr, w_op_ok, w_start_ok, w_start_err;
  logic              w_div_start, w_div_done, w_med_hit;
  logic [SUM_W-1:0]  w_acc_sum;
  logic [DATA_W-1:0] w_div_quot, w_a_i, w_a_j, w_med_res, w_scan_res;
  logic [CNT_W-1:0]  w_lt_tot, w_eq_tot;

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_err   = r_res_err;

`ifdef ARRAY_STATS_MODE_EN
  assign w_op_ok = (bus.op != OP_RSVD);
`else
  assign w_op_ok = (bus.op != OP_RSVD) && (bus.op != OP_MODE);
`endif

  assign w_wr        = bus.in_valid && r_in_ready;
  assign w_start_ok  = bus.start && (r_state == ST_FULL) && w_op_ok;
  assign w_start_err = bus.start && ((r_state == ST_LOAD) ||
                                     ((r_state == ST_FULL) && !w_op_ok));
  assign w_acc_sum   = r_sum + SUM_W'(r_buf[r_idx]);
  assign w_div_start = (r_state == ST_ACC) && (r_idx == LAST) && !bus.clear;

  // Scan compare: totals include the current j, so they are final when j = LAST.
  assign w_a_i     = r_buf[r_i];
  assign w_a_j     = r_buf[r_j];
  assign w_lt_tot  = r_lt + CNT_W'(w_a_j < w_a_i);
  assign w_eq_tot  = r_eq + CNT_W'(w_a_j == w_a_i);
  assign w_med_hit = (w_lt_tot <= CNT_W'(MED_IDX)) &&
                     ((TOT_W'(w_lt_tot) + TOT_W'(w_eq_tot)) > TOT_W'(MED_IDX));
  assign w_med_res = r_med_found ? r_med_val : w_a_i;

`ifdef ARRAY_STATS_MODE_EN
  logic [1:0]        r_op;
  logic [CNT_W-1:0]  r_best_cnt;
  logic [DATA_W-1:0] r_best_val;
  logic              w_mode_better;

  // Strictly higher count wins; equal count goes to the smaller value.
  assign w_mode_better = (w_eq_tot > r_best_cnt) ||
                         ((w_eq_tot == r_best_cnt) && (w_a_i < r_best_val));
  assign w_scan_res    = (r_op == OP_MODE) ? (w_mode_better ? w_a_i : r_best_val)
                                           : w_med_res;

  // Mode tracking; best count starts at 0 so the first entry always wins.
  always_ff @(posedge clk) begin
    if (w_start_ok) begin
      r_op       <= bus.op;
      r_best_cnt <= '0;
      r_best_val <= '0;
    end else if ((r_state == ST_SCAN) && (r_j == LAST) && w_mode_better) begin
      r_best_cnt <= w_eq_tot;
      r_best_val <= w_a_i;
    end
  end
`else
  assign w_scan_res = w_med_res;
`endif

  array_stats_div u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (bus.clear),
    .i_start    (w_div_start),
    .i_dividend (w_acc_sum),
    .o_done_c   (w_div_done),
    .o_quot_c   (w_div_quot)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nx;
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_LOAD: begin
        if (bus.start)                      w_state_nx = ST_DONE;
        else if (w_wr && (r_count == LAST)) w_state_nx = ST_FULL;
      end
      ST_FULL: begin
        if (w_start_err)                    w_state_nx = ST_DONE;
        else if (w_start_ok)                w_state_nx = (bus.op == OP_AVG) ? ST_ACC : ST_SCAN;
      end
      ST_ACC:  if (r_idx == LAST)           w_state_nx = ST_DIV;
      ST_DIV:  if (w_div_done)              w_state_nx = ST_DONE;
      ST_SCAN: if ((r_i == LAST) && (r_j == LAST)) w_state_nx = ST_DONE;
      ST_DONE: if (bus.res_ready)           w_state_nx = (r_count == CNT_W'(N)) ? ST_FULL : ST_LOAD;
      default:                              w_state_nx = ST_LOAD;
    endcase
    if (bus.clear) w_state_nx = ST_LOAD;
  end

  // Output decode from the next state, registered below.
  always_comb begin
    w_in_ready_nx  = 1'b0;
    w_busy_nx      = 1'b0;
    w_res_valid_nx = 1'b0;
    case (w_state_nx)
      ST_LOAD:                  w_in_ready_nx  = 1'b1;
      ST_ACC, ST_DIV, ST_SCAN:  w_busy_nx      = 1'b1;
      ST_DONE:                  w_res_valid_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nx;
      r_busy      <= w_busy_nx;
      r_res_valid <= w_res_valid_nx;
    end
  end

  // Sample buffer; contents are don't-care after clear.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_count] <= bus.in_data;
  end

  // Counters, accumulator, scan state and result.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear) begin
      r_count     <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_lt        <= '0;
      r_eq        <= '0;
      r_med_found <= 1'b0;
      r_med_val   <= '0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      if (w_wr) r_count <= r_count + CNT_W'(1);
      if (w_start_ok) begin
        r_idx       <= '0;
        r_sum       <= '0;
        r_i         <= '0;
        r_j         <= '0;
        r_lt        <= '0;
        r_eq        <= '0;
        r_med_found <= 1'b0;
      end
      if (w_start_err) begin
        r_res_data <= '0;
        r_res_err  <= 1'b1;
      end
      case (r_state)
        ST_ACC: begin
          r_sum <= w_acc_sum;
          r_idx <= r_idx + CNT_W'(1);
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_res_data <= w_div_quot;
            r_res_err  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (r_j == LAST) begin
            r_j  <= '0;
            r_i  <= r_i + CNT_W'(1);
            r_lt <= '0;
            r_eq <= '0;
            if (w_med_hit && !r_med_found) begin
              r_med_found <= 1'b1;
              r_med_val   <= w_a_i;
            end
            if (r_i == LAST) begin
              r_res_data <= w_scan_res;
              r_res_err  <= 1'b0;
            end
          end else begin
            r_j  <= r_j + CNT_W'(1);
            r_lt <= w_lt_tot;
            r_eq <= w_eq_tot;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_array_stats_ctrl.sv
// Directed + randomized bench for array_stats_ctrl with a sort/histogram
// reference model. Honours ARRAY_STATS_MODE_EN for the op 2 expectation.
`timescale 1ns/1ps
module tb_array_stats_ctrl;
  import array_stats_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ref_buf [15];

  array_stats_if bus();

  array_stats_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_avg();
    int s = 0;
    for (int k = 0; k < 15; k++) s += int'(ref_buf[k]);
    return s / 15;
  endfunction

  function automatic int m_median();
    int q[$];
    for (int k = 0; k < 15; k++) q.push_back(int'(ref_buf[k]));
    q.sort();
    return q[7];
  endfunction

  function automatic int m_mode();
    int hist [256];
    int best_v = 0;
    int best_c = 0;
    for (int v = 0; v < 256; v++) hist[v] = 0;
    for (int k = 0; k < 15; k++) hist[ref_buf[k]]++;
    for (int v = 0; v < 256; v++)
      if (hist[v] > best_c) begin best_c = hist[v]; best_v = v; end
    return best_v;
  endfunction

  task automatic expect_for(input logic [1:0] op, output int d, output logic e, output int lat);
    case (op)
      2'd0: begin d = m_avg();    e = 1'b0; lat = 28;  end
      2'd1: begin d = m_median(); e = 1'b0; lat = 226; end
`ifdef ARRAY_STATS_MODE_EN
      2'd2: begin d = m_mode();   e = 1'b0; lat = 226; end
`else
      2'd2: begin d = 0;          e = 1'b1; lat = 1;   end
`endif
      default: begin d = 0;       e = 1'b1; lat = 1;   end
    endcase
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic load(input int from, input int upto);
    for (int k = from; k < upto; k++) begin
      int   guard = 0;
      logic hs;
      bus.in_valid = 1'b1;
      bus.in_data  = ref_buf[k];
      do begin
        hs = bus.in_ready;
        step();
        guard++;
      end while (!hs && guard < 50);
      if (!hs) chk("load_timeout", 32'(hs), 32'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.res_valid && n < 600) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input string tag);
    int   d, lat, n;
    logic e;
    expect_for(op, d, e, lat);
    bus.op    = op;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (!e) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_valid(n);
    chk({tag, "_lat"},  32'(n),            32'(lat));
    chk({tag, "_data"}, 32'(bus.res_data), 32'(d));
    chk({tag, "_err"},  32'(bus.res_err),  32'(e));
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk({tag, "_acc"}, 32'(bus.res_valid), 32'd0);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.clear = 1'b0; bus.start = 1'b0;
    bus.op = 2'd0; bus.res_ready = 1'b0; rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_res_err",   32'(bus.res_err),   32'd0);

    // 1..15: average 8, then stalled sample must not disturb the buffer
    for (int k = 0; k < 15; k++) ref_buf[k] = 8'(k + 1);
    load(0, 15);
    run_op(2'd0, "avg_inc");
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    step(); step(); step();
    chk("stall_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    run_op(2'd1, "med_inc");

    // all 255, two statistics without reload
    pulse_clear();
    for (int k = 0; k < 15; k++) ref_buf[k] = 8'd255;
    load(0, 15);
    run_op(2'd0, "avg_255");
    run_op(2'd1, "med_255");

    pulse_clear();
    for (int k = 0; k < 15; k++) ref_buf[k] = 8'(15 - k);
    load(0, 15);
    run_op(2'd1, "med_desc");

    pulse_clear();
    for (int k = 0; k < 15; k++) ref_buf[k] = (k < 8) ? 8'd5 : 8'd9;
    load(0, 15);
    run_op(2'd1, "med_5_9");

    // mode tie between 7 and 9 resolves to 7
    pulse_clear();
    ref_buf = '{8'd7, 8'd7, 8'd7, 8'd9, 8'd9, 8'd9, 8'd1, 8'd2, 8'd3, 8'd4,
                8'd5, 8'd6, 8'd10, 8'd11, 8'd12};
    load(0, 15);
    run_op(2'd2, "mode_tie");
    run_op(2'd3, "rsvd");

    // start with a partial buffer, result held under back-pressure
    pulse_clear();
    for (int k = 0; k < 15; k++) ref_buf[k] = 8'($urandom);
    load(0, 10);
    bus.op = 2'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid(n);
    chk("part_lat",  32'(n),            32'd1);
    chk("part_err",  32'(bus.res_err),  32'd1);
    chk("part_data", 32'(bus.res_data), 32'd0);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_err",   32'(bus.res_err),   32'd1);
      chk("hold_data",  32'(bus.res_data),  32'd0);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    chk("part_ret_load", 32'(bus.in_ready),  32'd1);
    chk("part_ret_rv",   32'(bus.res_valid), 32'd0);
    load(10, 15);
    run_op(2'd0, "avg_after_part");

    // clear at scan cycle 100
    bus.op = 2'd1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (99) step();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr_scan_busy",  32'(bus.busy),      32'd0);
    chk("clr_scan_ready", 32'(bus.in_ready),  32'd1);
    chk("clr_scan_rv",    32'(bus.res_valid), 32'd0);
    repeat (200) step();
    chk("clr_scan_late_rv", 32'(bus.res_valid), 32'd0);

    // clear and start on the same edge
    for (int k = 0; k < 15; k++) ref_buf[k] = 8'($urandom);
    load(0, 15);
    bus.op = 2'd0; bus.start = 1'b1; bus.clear = 1'b1;
    step();
    bus.start = 1'b0; bus.clear = 1'b0;
    chk("clr_start_busy",  32'(bus.busy),     32'd0);
    chk("clr_start_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) step();
    chk("clr_start_rv", 32'(bus.res_valid), 32'd0);
    load(0, 15);
    run_op(2'd0, "avg_after_clr");

    // reset in the middle of an average
    bus.op = 2'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mrst_busy",      32'(bus.busy),      32'd0);
    chk("mrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("mrst_res_data",  32'(bus.res_data),  32'd0);
    chk("mrst_res_err",   32'(bus.res_err),   32'd0);

    // random buffers and ops, small value ranges to force ties
    for (int it = 0; it < 12; it++) begin
      pulse_clear();
      for (int k = 0; k < 15; k++)
        ref_buf[k] = (it % 2 == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom);
      load(0, 15);
      run_op(2'($urandom_range(0, 3)), "rnd_a");
      run_op(2'($urandom_range(0, 3)), "rnd_b");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
